// File: rtl/bp_be_pkg.sv
// Shared types for the BE-to-FE command sequencer: FE command layout,
// buffer entry, sequencer state and the fence-opcode classifier.
package bp_be_pkg;

   typedef enum logic [0:0] {
      e_bp_default_cfg = 1'b0
   } bp_params_e;

   localparam int vaddr_width_gp = 39;
   localparam int asid_width_gp  = 10;
   localparam int meta_width_gp  = 8;

   typedef enum logic [3:0] {
      e_op_state_reset         = 4'd0,
      e_op_pc_redirection      = 4'd1,
      e_op_icache_fill_restart = 4'd2,
      e_op_icache_fill_resume  = 4'd3,
      e_op_icache_fence        = 4'd4,
      e_op_itlb_fill_restart   = 4'd5,
      e_op_itlb_fill_resume    = 4'd6,
      e_op_itlb_fence          = 4'd7,
      e_op_attaboy             = 4'd8,
      e_op_wait                = 4'd9
   } bp_fe_command_queue_opcode_e;

   localparam int op_width_gp = $bits(bp_fe_command_queue_opcode_e);

   typedef struct packed {
      bp_fe_command_queue_opcode_e opcode;
      logic [vaddr_width_gp-1:0]   vaddr;
      logic [asid_width_gp-1:0]    asid;
      logic [meta_width_gp-1:0]    meta;
   } bp_fe_cmd_s;

   typedef struct packed {
      logic       live;
      logic       spec;
      bp_fe_cmd_s cmd;
   } bp_be_fe_cmd_entry_s;

   typedef enum logic {
      e_run   = 1'b0,
      e_fence = 1'b1
   } bp_be_fe_cmd_state_e;

   function automatic int bp_fe_cmd_width(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return $bits(bp_fe_cmd_s);
         default:          return $bits(bp_fe_cmd_s);
      endcase
   endfunction

   // Opcodes that change FE state and must fence the speculative stream.
   function automatic logic bp_be_fe_cmd_is_fence(
      input bp_fe_command_queue_opcode_e op
   );
      return op inside {e_op_state_reset, e_op_icache_fence,
                        e_op_itlb_fence, e_op_wait};
   endfunction

endpackage

// File: rtl/bp_be_fe_cmd_buffer.sv
// Circular entry store with occupancy, next/registered full/empty and
// per-entry speculative squash. Ports: enq, deq, squash, head, free count.
// BP_BE_FE_CMD_STATS_EN adds squash_hit_o for the squash counter.
module bp_be_fe_cmd_buffer
   import bp_be_pkg::*;
#(
   parameter int els_p = 4,
   localparam int ptr_w_lp = $clog2(els_p),
   localparam int cnt_w_lp = $clog2(els_p + 1)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                enq_v_i,
   input  bp_be_fe_cmd_entry_s enq_entry_i,
   input  logic                squash_i,
   input  logic                deq_i,
   output logic                head_live_o,
   output bp_fe_cmd_s          head_cmd_o,
   output logic [cnt_w_lp-1:0] free_o,
   output logic                empty_n_o,
   output logic                empty_r_o,
   output logic                full_n_o,
   output logic                full_r_o
`ifdef BP_BE_FE_CMD_STATS_EN
  ,output logic                squash_hit_o
`endif
);

   bp_be_fe_cmd_entry_s r_mem [els_p];
   logic [ptr_w_lp-1:0] r_rptr;
   logic [ptr_w_lp-1:0] r_wptr;
   logic [cnt_w_lp-1:0] r_cnt;
   logic [cnt_w_lp-1:0] w_cnt_n;
   logic                r_empty;
   logic                r_full;

   assign w_cnt_n = r_cnt + cnt_w_lp'(enq_v_i)
                  - cnt_w_lp'(deq_i);

   assign empty_n_o   = (w_cnt_n == '0);
   assign full_n_o    = (w_cnt_n == cnt_w_lp'(els_p));
   assign empty_r_o   = r_empty;
   assign full_r_o    = r_full;
   assign free_o      = cnt_w_lp'(els_p) - r_cnt;
   assign head_live_o = r_mem[r_rptr].live;
   assign head_cmd_o  = r_mem[r_rptr].cmd;

`ifdef BP_BE_FE_CMD_STATS_EN
   logic w_hit;
   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < els_p; i++) begin
         if (r_mem[i].live && r_mem[i].spec
             && !(deq_i && (ptr_w_lp'(i) == r_rptr)))
            w_hit = 1'b1;
      end
   end
   assign squash_hit_o = squash_i & w_hit;
`endif

   // Popped slots are zeroed so stale entries never look live; the
   // enqueue write is last so it wins when full with a same-cycle pop.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < els_p; i++) r_mem[i] <= '0;
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_cnt   <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
      end else begin
         for (int i = 0; i < els_p; i++) begin
            if (squash_i && r_mem[i].spec)
               r_mem[i].live <= 1'b0;
         end
         if (deq_i) begin
            r_mem[r_rptr] <= '0;
            r_rptr        <= r_rptr + ptr_w_lp'(1);
         end
         if (enq_v_i) begin
            r_mem[r_wptr] <= enq_entry_i;
            r_wptr        <= r_wptr + ptr_w_lp'(1);
         end
         r_cnt   <= w_cnt_n;
         r_empty <= empty_n_o;
         r_full  <= full_n_o;
      end
   end

endmodule

// File: rtl/bp_be_fe_cmd_sequencer.sv
// Schedules commit and issue commands into one FE command buffer with
// squash, attaboy drop and fencing. Optional: BP_BE_FE_CMD_STATS_EN.
module bp_be_fe_cmd_sequencer
   import bp_be_pkg::*;
#(
   parameter bp_params_e bp_params_p = e_bp_default_cfg,
   parameter int els_p = 4,
   localparam int fe_cmd_width_lp = bp_fe_cmd_width(bp_params_p)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [fe_cmd_width_lp-1:0] nonspec_cmd_i,
   input  logic                       nonspec_v_i,
   input  logic [fe_cmd_width_lp-1:0] spec_cmd_i,
   input  logic                       spec_v_i,
   output logic                       spec_ready_o,
   output logic [fe_cmd_width_lp-1:0] fe_cmd_o,
   output logic                       fe_cmd_v_o,
   input  logic                       fe_cmd_yumi_i,
   output logic                       empty_n_o,
   output logic                       empty_r_o,
   output logic                       full_n_o,
   output logic                       full_r_o,
   output logic                       fence_o
`ifdef BP_BE_FE_CMD_STATS_EN
  ,output logic [15:0]                attaboy_drop_cnt_o
  ,output logic [15:0]                squash_cnt_o
  ,output logic [15:0]                fence_cycle_cnt_o
`endif
);

   localparam int cnt_w_lp = $clog2(els_p + 1);
   localparam int op_w_lp  = op_width_gp;

   bp_be_fe_cmd_state_e         r_state;
   logic                        r_fence;
   bp_fe_command_queue_opcode_e w_spec_op;
   bp_fe_command_queue_opcode_e w_nonspec_op;
   bp_be_fe_cmd_entry_s         w_enq_entry;
   bp_fe_cmd_s                  w_head_cmd;
   logic [cnt_w_lp-1:0]         w_free;
   logic w_head_live, w_live, w_dead_pop, w_deq;
   logic w_attaboy, w_room, w_spec_acc, w_drop;
   logic w_spec_enq, w_enq_v, w_ns_fence;

   assign w_spec_op = bp_fe_command_queue_opcode_e'(
      spec_cmd_i[fe_cmd_width_lp-1 -: op_w_lp]);
   assign w_nonspec_op = bp_fe_command_queue_opcode_e'(
      nonspec_cmd_i[fe_cmd_width_lp-1 -: op_w_lp]);

   // The last slot is kept for commit; attaboys may use it only to be
   // dropped, so issue is never stalled on a hint.
   assign w_attaboy  = (w_spec_op == e_op_attaboy);
   assign w_room     = w_attaboy ? (w_free >= cnt_w_lp'(1))
                                 : (w_free >= cnt_w_lp'(2));
   assign spec_ready_o = ~reset_i & (r_state == e_run)
                       & ~nonspec_v_i & w_room;
   assign w_spec_acc = spec_v_i & spec_ready_o;
   assign w_drop     = w_spec_acc & w_attaboy
                     & (w_free <= cnt_w_lp'(1));
   assign w_spec_enq = w_spec_acc & ~w_drop;
   assign w_enq_v    = nonspec_v_i | w_spec_enq;
   assign w_ns_fence = nonspec_v_i
                     & bp_be_fe_cmd_is_fence(w_nonspec_op);

   always_comb begin
      w_enq_entry      = '0;
      w_enq_entry.live = 1'b1;
      w_enq_entry.spec = ~nonspec_v_i;
      w_enq_entry.cmd  = nonspec_v_i ? nonspec_cmd_i : spec_cmd_i;
   end

   // Dead heads are retired internally one per cycle, never shown.
   assign w_live     = ~empty_r_o & w_head_live;
   assign w_dead_pop = ~empty_r_o & ~w_head_live;
   assign w_deq      = (fe_cmd_yumi_i & w_live) | w_dead_pop;
   assign fe_cmd_v_o = w_live;
   assign fe_cmd_o   = w_head_cmd;
   assign fence_o    = r_fence;

`ifdef BP_BE_FE_CMD_STATS_EN
   logic w_squash_hit;
`endif

   bp_be_fe_cmd_buffer #(.els_p(els_p)) u_buf (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .enq_v_i     (w_enq_v),
      .enq_entry_i (w_enq_entry),
      .squash_i    (nonspec_v_i),
      .deq_i       (w_deq),
      .head_live_o (w_head_live),
      .head_cmd_o  (w_head_cmd),
      .free_o      (w_free),
      .empty_n_o   (empty_n_o),
      .empty_r_o   (empty_r_o),
      .full_n_o    (full_n_o),
      .full_r_o    (full_r_o)
`ifdef BP_BE_FE_CMD_STATS_EN
     ,.squash_hit_o(w_squash_hit)
`endif
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= e_run;
         r_fence <= 1'b0;
      end else begin
         unique case (r_state)
            e_run: begin
               if (w_ns_fence) begin
                  r_state <= e_fence;
                  r_fence <= 1'b1;
               end
            end
            e_fence: begin
               if (!w_ns_fence && empty_r_o) begin
                  r_state <= e_run;
                  r_fence <= 1'b0;
               end
            end
            default: begin
               r_state <= e_run;
               r_fence <= 1'b0;
            end
         endcase
      end
   end

`ifdef BP_BE_FE_CMD_STATS_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         attaboy_drop_cnt_o <= '0;
         squash_cnt_o       <= '0;
         fence_cycle_cnt_o  <= '0;
      end else begin
         if (w_drop && attaboy_drop_cnt_o != 16'hFFFF)
            attaboy_drop_cnt_o <= attaboy_drop_cnt_o + 16'd1;
         if (w_squash_hit && squash_cnt_o != 16'hFFFF)
            squash_cnt_o <= squash_cnt_o + 16'd1;
         if (r_fence && fence_cycle_cnt_o != 16'hFFFF)
            fence_cycle_cnt_o <= fence_cycle_cnt_o + 16'd1;
      end
   end
`endif

   a_nonspec_full: assert property (@(posedge clk_i)
      disable iff (reset_i) !(nonspec_v_i && full_r_o));
   a_yumi_no_v: assert property (@(posedge clk_i)
      disable iff (reset_i) !(fe_cmd_yumi_i && !fe_cmd_v_o));

endmodule

// File: tb/tb_bp_be_fe_cmd_sequencer.sv
// Directed bench for bp_be_fe_cmd_sequencer.
// Inputs change 1ns after posedge; outputs are checked before next edge.
module tb_bp_be_fe_cmd_sequencer;
   import bp_be_pkg::*;

   localparam int W = bp_fe_cmd_width(e_bp_default_cfg);

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic [W-1:0] nonspec_cmd_i;
   logic         nonspec_v_i;
   logic [W-1:0] spec_cmd_i;
   logic         spec_v_i;
   logic         spec_ready_o;
   logic [W-1:0] fe_cmd_o;
   logic         fe_cmd_v_o;
   logic         fe_cmd_yumi_i;
   logic         empty_n_o, empty_r_o;
   logic         full_n_o, full_r_o;
   logic         fence_o;
`ifdef BP_BE_FE_CMD_STATS_EN
   logic [15:0]  attaboy_drop_cnt_o;
   logic [15:0]  squash_cnt_o;
   logic [15:0]  fence_cycle_cnt_o;
`endif

   int vec  = 0;
   int errs = 0;

   always #5 clk_i = ~clk_i;

   bp_be_fe_cmd_sequencer #(.els_p(4)) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .nonspec_cmd_i (nonspec_cmd_i),
      .nonspec_v_i   (nonspec_v_i),
      .spec_cmd_i    (spec_cmd_i),
      .spec_v_i      (spec_v_i),
      .spec_ready_o  (spec_ready_o),
      .fe_cmd_o      (fe_cmd_o),
      .fe_cmd_v_o    (fe_cmd_v_o),
      .fe_cmd_yumi_i (fe_cmd_yumi_i),
      .empty_n_o     (empty_n_o),
      .empty_r_o     (empty_r_o),
      .full_n_o      (full_n_o),
      .full_r_o      (full_r_o),
      .fence_o       (fence_o)
`ifdef BP_BE_FE_CMD_STATS_EN
     ,.attaboy_drop_cnt_o(attaboy_drop_cnt_o)
     ,.squash_cnt_o      (squash_cnt_o)
     ,.fence_cycle_cnt_o (fence_cycle_cnt_o)
`endif
   );

   function automatic logic [W-1:0] mk(
      input bp_fe_command_queue_opcode_e op,
      input logic [31:0] va
   );
      bp_fe_cmd_s c;
      c        = '0;
      c.opcode = op;
      c.vaddr  = 39'(va);
      c.asid   = 10'h5;
      return c;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      nonspec_v_i   = 1'b0;
      spec_v_i      = 1'b0;
      fe_cmd_yumi_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      idle();
      nonspec_cmd_i = '0;
      spec_cmd_i    = mk(e_op_pc_redirection, 32'h0);
      tick();
      tick();
      vec++;
      if (fe_cmd_v_o !== 1'b0) begin
         errs++; $display("FAIL rst_v got %b want 0", fe_cmd_v_o);
      end
      vec++;
      if (spec_ready_o !== 1'b0) begin
         errs++; $display("FAIL rst_rdy got %b want 0", spec_ready_o);
      end
      vec++;
      if (fence_o !== 1'b0) begin
         errs++; $display("FAIL rst_fence got %b want 0", fence_o);
      end
      vec++;
      if ({empty_n_o, empty_r_o} !== 2'b11) begin
         errs++;
         $display("FAIL rst_empty got %b%b want 11",
                  empty_n_o, empty_r_o);
      end
      vec++;
      if ({full_n_o, full_r_o} !== 2'b00) begin
         errs++;
         $display("FAIL rst_full got %b%b want 00",
                  full_n_o, full_r_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] c [3];
      logic         ev;
      for (int i = 0; i < 3; i++)
         c[i] = mk(e_op_pc_redirection, 32'h1000 + 32'(4 * i));
      reset_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         spec_v_i      = (i < 3);
         spec_cmd_i    = c[(i < 3) ? i : 2];
         fe_cmd_yumi_i = (i >= 1 && i <= 3);
         ev            = (i >= 1 && i <= 3);
         #1;
         if (i < 3) begin
            vec++;
            if (spec_ready_o !== 1'b1) begin
               errs++;
               $display("FAIL b2b_rdy[%0d] got %b want 1",
                        i, spec_ready_o);
            end
         end
         vec++;
         if (fe_cmd_v_o !== ev) begin
            errs++;
            $display("FAIL b2b_v[%0d] got %b want %b",
                     i, fe_cmd_v_o, ev);
         end
         if (ev) begin
            vec++;
            if (fe_cmd_o !== c[i-1]) begin
               errs++;
               $display("FAIL b2b_cmd[%0d] got %h want %h",
                        i, fe_cmd_o, c[i-1]);
            end
         end
         tick();
      end
      idle();
      #1;
      vec++;
      if (empty_r_o !== 1'b1) begin
         errs++; $display("FAIL b2b_empty got %b want 1", empty_r_o);
      end
   endtask

   task automatic test_squash();
      logic [W-1:0] a, r, t;
      logic         ev;
      a = mk(e_op_attaboy, 32'h2000);
      r = mk(e_op_pc_redirection, 32'h2004);
      t = mk(e_op_pc_redirection, 32'h8000_0100);
      for (int i = 0; i < 7; i++) begin
         idle();
         if (i == 0) begin spec_v_i = 1'b1; spec_cmd_i = a; end
         if (i == 1) begin spec_v_i = 1'b1; spec_cmd_i = r; end
         if (i == 2) begin nonspec_v_i = 1'b1; nonspec_cmd_i = t; end
         if (i == 5) fe_cmd_yumi_i = 1'b1;
         ev = (i == 1 || i == 2 || i == 5);
         #1;
         if (i < 2) begin
            vec++;
            if (spec_ready_o !== 1'b1) begin
               errs++;
               $display("FAIL sq_rdy[%0d] got %b want 1",
                        i, spec_ready_o);
            end
         end
         if (i >= 1 && i <= 5) begin
            vec++;
            if (fe_cmd_v_o !== ev) begin
               errs++;
               $display("FAIL sq_v[%0d] got %b want %b",
                        i, fe_cmd_v_o, ev);
            end
         end
         if (i == 1 || i == 2) begin
            vec++;
            if (fe_cmd_o !== a) begin
               errs++;
               $display("FAIL sq_head[%0d] got %h want %h",
                        i, fe_cmd_o, a);
            end
         end
         if (i == 5) begin
            vec++;
            if (fe_cmd_o !== t) begin
               errs++;
               $display("FAIL sq_trap got %h want %h", fe_cmd_o, t);
            end
         end
         if (i == 6) begin
            vec++;
            if (empty_r_o !== 1'b1) begin
               errs++;
               $display("FAIL sq_empty got %b want 1", empty_r_o);
            end
         end
         tick();
      end
`ifdef BP_BE_FE_CMD_STATS_EN
      vec++;
      if (squash_cnt_o !== 16'd1) begin
         errs++; $display("FAIL sq_cnt got %0d want 1", squash_cnt_o);
      end
`endif
   endtask

   task automatic test_drop();
      logic [W-1:0] n [4];
      for (int i = 0; i < 4; i++)
         n[i] = mk(e_op_pc_redirection, 32'h3000 + 32'(16 * i));
      for (int i = 0; i < 3; i++) begin
         idle();
         nonspec_v_i   = 1'b1;
         nonspec_cmd_i = n[i];
         tick();
      end
      idle();
      spec_v_i   = 1'b1;
      spec_cmd_i = mk(e_op_attaboy, 32'h3100);
      #1;
      vec++;
      if (spec_ready_o !== 1'b1) begin
         errs++; $display("FAIL drop_rdy got %b want 1", spec_ready_o);
      end
      tick();
      spec_cmd_i = mk(e_op_pc_redirection, 32'h3200);
      #1;
      vec++;
      if (spec_ready_o !== 1'b0) begin
         errs++;
         $display("FAIL drop_redir_rdy got %b want 0", spec_ready_o);
      end
      vec++;
      if (full_r_o !== 1'b0) begin
         errs++; $display("FAIL drop_notfull got %b want 0", full_r_o);
      end
`ifdef BP_BE_FE_CMD_STATS_EN
      vec++;
      if (attaboy_drop_cnt_o !== 16'd1) begin
         errs++;
         $display("FAIL drop_cnt got %0d want 1", attaboy_drop_cnt_o);
      end
`endif
      tick();
      idle();
      nonspec_v_i   = 1'b1;
      nonspec_cmd_i = n[3];
      #1;
      vec++;
      if (full_n_o !== 1'b1) begin
         errs++; $display("FAIL fill_full_n got %b want 1", full_n_o);
      end
      tick();
      idle();
      spec_cmd_i = mk(e_op_attaboy, 32'h3300);
      #1;
      vec++;
      if ({full_r_o, spec_ready_o} !== 2'b10) begin
         errs++;
         $display("FAIL full_state got %b%b want 10",
                  full_r_o, spec_ready_o);
      end
      for (int i = 0; i < 4; i++) begin
         fe_cmd_yumi_i = 1'b1;
         #1;
         vec++;
         if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== n[i]) begin
            errs++;
            $display("FAIL drain[%0d] got v=%b %h want v=1 %h",
                     i, fe_cmd_v_o, fe_cmd_o, n[i]);
         end
         tick();
      end
      idle();
      #1;
      vec++;
      if (empty_r_o !== 1'b1) begin
         errs++; $display("FAIL drain_empty got %b want 1", empty_r_o);
      end
   endtask

   task automatic test_fence();
      logic [W-1:0] f, r;
      f = mk(e_op_icache_fence, 32'h4000);
      r = mk(e_op_pc_redirection, 32'h4004);
      idle();
      nonspec_v_i   = 1'b1;
      nonspec_cmd_i = f;
      tick();
      idle();
      spec_v_i      = 1'b1;
      spec_cmd_i    = r;
      fe_cmd_yumi_i = 1'b1;
      #1;
      vec++;
      if ({fence_o, spec_ready_o, fe_cmd_v_o} !== 3'b101) begin
         errs++;
         $display("FAIL fen1 fence/rdy/v got %b%b%b want 101",
                  fence_o, spec_ready_o, fe_cmd_v_o);
      end
      vec++;
      if (fe_cmd_o !== f) begin
         errs++; $display("FAIL fen1_cmd got %h want %h", fe_cmd_o, f);
      end
      tick();
      fe_cmd_yumi_i = 1'b0;
      #1;
      vec++;
      if ({fence_o, spec_ready_o, empty_r_o} !== 3'b101) begin
         errs++;
         $display("FAIL fen2 fence/rdy/empty got %b%b%b want 101",
                  fence_o, spec_ready_o, empty_r_o);
      end
      tick();
      #1;
      vec++;
      if ({fence_o, spec_ready_o} !== 2'b01) begin
         errs++;
         $display("FAIL fen3 fence/rdy got %b%b want 01",
                  fence_o, spec_ready_o);
      end
      tick();
      idle();
      fe_cmd_yumi_i = 1'b1;
      #1;
      vec++;
      if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== r) begin
         errs++;
         $display("FAIL fen4 got v=%b %h want v=1 %h",
                  fe_cmd_v_o, fe_cmd_o, r);
      end
      tick();
      idle();
   endtask

   task automatic test_arb();
      logic [W-1:0] n, s;
      n = mk(e_op_pc_redirection, 32'h5000);
      s = mk(e_op_pc_redirection, 32'h5100);
      idle();
      nonspec_v_i   = 1'b1;
      nonspec_cmd_i = n;
      spec_v_i      = 1'b1;
      spec_cmd_i    = s;
      #1;
      vec++;
      if (spec_ready_o !== 1'b0) begin
         errs++; $display("FAIL arb_rdy0 got %b want 0", spec_ready_o);
      end
      tick();
      nonspec_v_i   = 1'b0;
      fe_cmd_yumi_i = 1'b1;
      #1;
      vec++;
      if (spec_ready_o !== 1'b1) begin
         errs++; $display("FAIL arb_rdy1 got %b want 1", spec_ready_o);
      end
      vec++;
      if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== n) begin
         errs++;
         $display("FAIL arb_head0 got v=%b %h want v=1 %h",
                  fe_cmd_v_o, fe_cmd_o, n);
      end
      tick();
      spec_v_i = 1'b0;
      #1;
      vec++;
      if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== s) begin
         errs++;
         $display("FAIL arb_head1 got v=%b %h want v=1 %h",
                  fe_cmd_v_o, fe_cmd_o, s);
      end
      tick();
      idle();
      #1;
      vec++;
      if (empty_r_o !== 1'b1) begin
         errs++; $display("FAIL arb_empty got %b want 1", empty_r_o);
      end
   endtask

   task automatic test_reset_mid();
      idle();
      spec_v_i   = 1'b1;
      spec_cmd_i = mk(e_op_pc_redirection, 32'h6000);
      tick();
      spec_cmd_i = mk(e_op_pc_redirection, 32'h6004);
      tick();
      idle();
      nonspec_v_i   = 1'b1;
      nonspec_cmd_i = mk(e_op_icache_fence, 32'h6008);
      tick();
      idle();
      #1;
      vec++;
      if ({empty_r_o, fence_o} !== 2'b01) begin
         errs++;
         $display("FAIL rm_pre empty/fence got %b%b want 01",
                  empty_r_o, fence_o);
      end
      reset_i = 1'b1;
      tick();
      vec++;
      if ({fe_cmd_v_o, empty_r_o, empty_n_o, full_r_o, fence_o}
          !== 5'b01100) begin
         errs++;
         $display("FAIL rm_post v/er/en/fr/fen got %b%b%b%b%b want 01100",
                  fe_cmd_v_o, empty_r_o, empty_n_o, full_r_o, fence_o);
      end
      reset_i    = 1'b0;
      spec_cmd_i = mk(e_op_pc_redirection, 32'h6010);
      #1;
      vec++;
      if (spec_ready_o !== 1'b1) begin
         errs++; $display("FAIL rm_run_rdy got %b want 1", spec_ready_o);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_squash();
      test_drop();
      test_fence();
      test_arb();
      test_reset_mid();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
